// File: rtl/controle_bobc.sv
// ---------------------------------------------------------------------------
// controle_bobc
//   Moore FSM that sequences a 16-bit polynomial datapath (RegX, RegS, RegH,
//   muxes M0/M1/M2 and ULA) so that it evaluates one of four functions of X
//   by Horner's scheme, with one ULA operation per cycle:
//     modo 00 : A*X^2 + B*X + C
//     modo 01 : A*X + B
//     modo 10 : X^2
//     modo 11 : 0 (clear)
//   Every control output is decoded from the state register alone.
//
// Ports
//   ck       in   1      clock, rising edge
//   rst      in   1      synchronous active-low reset
//   inicio   in   1      start request, sampled only in IDLE
//   modo     in   2      function select, captured together with inicio
//   lx       out  1      load RegX from NX
//   m0       out  2      M0 select: 00 Zero, 01 A, 10 B, 11 C
//   m1       out  2      M1 select: 00 outm0, 01 RegX, 10 RegS, 11 RegH
//   m2       out  2      M2 select: 00 RegX, 01 outm0, 10 RegS, 11 RegH
//   h        out  1      ULA op: 0 add, 1 multiply (low 16 bits)
//   ls       out  1      load RegS from the ULA result
//   lh       out  1      load RegH from the ULA result
//   pronto   out  1      one-cycle pulse, result valid in RegS
//   ocupado  out  1      high in every state except IDLE
//   n_ops    out  CNT_W  completed-computation count, wraps
// ---------------------------------------------------------------------------
module controle_bobc #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             inicio,
    input  logic [1:0]       modo,
    output logic             lx,
    output logic [1:0]       m0,
    output logic [1:0]       m1,
    output logic [1:0]       m2,
    output logic             h,
    output logic             ls,
    output logic             lh,
    output logic             pronto,
    output logic             ocupado,
    output logic [CNT_W-1:0] n_ops
);

    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StLoadX = 4'd1,
        StE1    = 4'd2,
        StE2    = 4'd3,
        StE3    = 4'd4,
        StE4    = 4'd5,
        StSq    = 4'd6,
        StClr   = 4'd7,
        StDone  = 4'd8
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       modo_q, modo_d;
    logic [CNT_W-1:0] n_ops_q, n_ops_d;

    always_ff @(posedge ck) begin
        if (!rst) begin
            state_q <= StIdle;
            modo_q  <= 2'b00;
            n_ops_q <= '0;
        end else begin
            state_q <= state_d;
            modo_q  <= modo_d;
            n_ops_q <= n_ops_d;
        end
    end

    // Next state. modo is captured only on an accepted start, so it stays
    // stable for the whole run whatever the host does meanwhile.
    always_comb begin
        state_d = StIdle;
        modo_d  = modo_q;
        n_ops_d = n_ops_q;
        case (state_q)
            StIdle: begin
                if (inicio) begin
                    modo_d  = modo;
                    state_d = StLoadX;
                end
            end
            StLoadX: begin
                unique case (modo_q)
                    2'b00, 2'b01: state_d = StE1;
                    2'b10:        state_d = StSq;
                    default:      state_d = StClr;
                endcase
            end
            StE1:    state_d = StE2;
            StE2:    state_d = (modo_q == 2'b00) ? StE3 : StDone;
            StE3:    state_d = StE4;
            StE4:    state_d = StDone;
            StSq:    state_d = StDone;
            StClr:   state_d = StDone;
            StDone: begin
                // inicio is deliberately not looked at here.
                n_ops_d = n_ops_q + CNT_W'(1);
                state_d = StIdle;
            end
            // Unused encodings recover to IDLE.
            default: state_d = StIdle;
        endcase
    end

    // Moore output decode.
    always_comb begin
        lx      = 1'b0;
        m0      = 2'b00;
        m1      = 2'b00;
        m2      = 2'b00;
        h       = 1'b0;
        ls      = 1'b0;
        lh      = 1'b0;
        pronto  = 1'b0;
        ocupado = 1'b1;
        case (state_q)
            StLoadX: lx = 1'b1;
            StE1: begin                 // H = A * X
                m0 = 2'b01;
                m1 = 2'b00;
                m2 = 2'b00;
                h  = 1'b1;
                lh = 1'b1;
            end
            StE2: begin                 // S = H + B
                m0 = 2'b10;
                m1 = 2'b11;
                m2 = 2'b01;
                ls = 1'b1;
            end
            StE3: begin                 // H = S * X
                m1 = 2'b10;
                m2 = 2'b00;
                h  = 1'b1;
                lh = 1'b1;
            end
            StE4: begin                 // S = H + C
                m0 = 2'b11;
                m1 = 2'b11;
                m2 = 2'b01;
                ls = 1'b1;
            end
            StSq: begin                 // S = X * X
                m1 = 2'b01;
                m2 = 2'b00;
                h  = 1'b1;
                ls = 1'b1;
            end
            StClr: begin                // S = 0 + 0
                m0 = 2'b00;
                m1 = 2'b00;
                m2 = 2'b01;
                ls = 1'b1;
            end
            StDone:  pronto = 1'b1;
            default: ocupado = 1'b0;    // IDLE and unused encodings
        endcase
    end

    assign n_ops = n_ops_q;

endmodule

// File: tb/tb_controle_bobc.sv
// Bench for controle_bobc: drives the FSM together with a small behavioural
// model of the polynomial datapath and compares the per-cycle control vector,
// the RegS result and n_ops against hand-computed values. A second instance
// with CNT_W=2 shares all inputs to exercise counter wrap.
module tb_controle_bobc;

    logic        ck = 1'b0;
    logic        rst;
    logic        inicio;
    logic [1:0]  modo;
    logic        lx, h, ls, lh, pronto, ocupado;
    logic [1:0]  m0, m1, m2;
    logic [7:0]  n_ops;

    logic        s_lx, s_h, s_ls, s_lh, s_pronto, s_ocupado;
    logic [1:0]  s_m0, s_m1, s_m2;
    logic [1:0]  s_n_ops;

    logic [15:0] nx, a_v, b_v, c_v;
    logic [15:0] reg_x, reg_s, reg_h;
    logic [15:0] outm0, outm1, outm2, ula;

    int n_vec = 0;
    int n_err = 0;

    always #5 ck = ~ck;

    controle_bobc #(.CNT_W(8)) u_dut (
        .ck(ck), .rst(rst), .inicio(inicio), .modo(modo),
        .lx(lx), .m0(m0), .m1(m1), .m2(m2), .h(h), .ls(ls), .lh(lh),
        .pronto(pronto), .ocupado(ocupado), .n_ops(n_ops)
    );

    controle_bobc #(.CNT_W(2)) u_dut_small (
        .ck(ck), .rst(rst), .inicio(inicio), .modo(modo),
        .lx(s_lx), .m0(s_m0), .m1(s_m1), .m2(s_m2), .h(s_h), .ls(s_ls), .lh(s_lh),
        .pronto(s_pronto), .ocupado(s_ocupado), .n_ops(s_n_ops)
    );

    // Datapath model driven by the 8-bit instance.
    always_comb begin
        case (m0)
            2'b00:   outm0 = 16'd0;
            2'b01:   outm0 = a_v;
            2'b10:   outm0 = b_v;
            default: outm0 = c_v;
        endcase
        case (m1)
            2'b00:   outm1 = outm0;
            2'b01:   outm1 = reg_x;
            2'b10:   outm1 = reg_s;
            default: outm1 = reg_h;
        endcase
        case (m2)
            2'b00:   outm2 = reg_x;
            2'b01:   outm2 = outm0;
            2'b10:   outm2 = reg_s;
            default: outm2 = reg_h;
        endcase
        ula = h ? 16'(outm1 * outm2) : 16'(outm1 + outm2);
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            reg_x <= '0;
            reg_s <= '0;
            reg_h <= '0;
        end else begin
            if (lx) reg_x <= nx;
            if (ls) reg_s <= ula;
            if (lh) reg_h <= ula;
        end
    end

    // Control vector: {lx, m0, m1, m2, h, ls, lh, pronto, ocupado}
    localparam logic [12:0] VIdle  = 13'b0_00_00_00_0_0_0_0_0;
    localparam logic [12:0] VLoadX = 13'b1_00_00_00_0_0_0_0_1;
    localparam logic [12:0] VE1    = 13'b0_01_00_00_1_0_1_0_1;
    localparam logic [12:0] VE2    = 13'b0_10_11_01_0_1_0_0_1;
    localparam logic [12:0] VE3    = 13'b0_00_10_00_1_0_1_0_1;
    localparam logic [12:0] VE4    = 13'b0_11_11_01_0_1_0_0_1;
    localparam logic [12:0] VSq    = 13'b0_00_01_00_1_1_0_0_1;
    localparam logic [12:0] VClr   = 13'b0_00_00_01_0_1_0_0_1;
    localparam logic [12:0] VDone  = 13'b0_00_00_00_0_0_0_1_1;

    logic [12:0] vec;
    assign vec = {lx, m0, m1, m2, h, ls, lh, pronto, ocupado};

    function automatic int run_len(input logic [1:0] md);
        case (md)
            2'b00:   return 6;
            2'b01:   return 4;
            default: return 3;
        endcase
    endfunction

    // Expected vector i cycles after the accepted start (i=0 is LOADX).
    function automatic logic [12:0] exp_vec(input logic [1:0] md, input int i);
        if (i == 0) return VLoadX;
        case (md)
            2'b00: begin
                case (i)
                    1: return VE1;
                    2: return VE2;
                    3: return VE3;
                    4: return VE4;
                    default: return VDone;
                endcase
            end
            2'b01: begin
                case (i)
                    1: return VE1;
                    2: return VE2;
                    default: return VDone;
                endcase
            end
            2'b10:   return (i == 1) ? VSq : VDone;
            default: return (i == 1) ? VClr : VDone;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    // Starts a run from IDLE and checks every cycle up to and including DONE.
    task automatic run_seq(input string tag, input logic [1:0] md);
        int len;
        len    = run_len(md);
        modo   = md;
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s vec c%0d", tag, i + 1), 32'(vec), 32'(exp_vec(md, i)));
            if (i < len - 1) step();
        end
    endtask

    initial begin
        rst = 1'b0; inicio = 1'b0; modo = 2'b00;
        nx = '0; a_v = '0; b_v = '0; c_v = '0;
        step();
        step();
        check("reset vec", 32'(vec), 32'(VIdle));
        check("reset n_ops", 32'(n_ops), 32'd0);
        rst = 1'b1;
        step();
        check("idle vec", 32'(vec), 32'(VIdle));

        // 1: 2*9 + 5*3 + 7 = 40
        nx = 16'd3; a_v = 16'd2; b_v = 16'd5; c_v = 16'd7;
        run_seq("t1", 2'b00);
        check("t1 result", 32'(reg_s), 32'd40);
        step();
        check("t1 idle vec", 32'(vec), 32'(VIdle));
        check("t1 n_ops", 32'(n_ops), 32'd1);
        check("t1 hold", 32'(reg_s), 32'd40);

        // 2: 3*4 + 1 = 13
        nx = 16'd4; a_v = 16'd3; b_v = 16'd1;
        run_seq("t2", 2'b01);
        check("t2 result", 32'(reg_s), 32'd13);
        step();
        check("t2 n_ops", 32'(n_ops), 32'd2);

        // 3: 300^2 mod 2^16 = 24464, then clear
        nx = 16'd300;
        run_seq("t3 sq", 2'b10);
        check("t3 sq result", 32'(reg_s), 32'd24464);
        step();
        run_seq("t3 clr", 2'b11);
        check("t3 clr result", 32'(reg_s), 32'd0);
        step();
        check("t3 n_ops", 32'(n_ops), 32'd4);

        // 4: inicio held and modo toggling during a modo-00 run
        nx = 16'd3; a_v = 16'd2; b_v = 16'd5; c_v = 16'd7;
        modo = 2'b00; inicio = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t4 vec c%0d", i + 1), 32'(vec), 32'(exp_vec(2'b00, i)));
            modo = modo + 2'b01;
            if (i < 5) step();
        end
        check("t4 result", 32'(reg_s), 32'd40);
        modo = 2'b00;
        step();
        check("t4 idle after done", 32'(vec), 32'(VIdle));
        check("t4 n_ops", 32'(n_ops), 32'd5);
        step();
        check("t4 restart", 32'(vec), 32'(VLoadX));
        inicio = 1'b0;
        for (int i = 1; i < 6; i++) begin
            step();
            check($sformatf("t4b vec c%0d", i + 1), 32'(vec), 32'(exp_vec(2'b00, i)));
        end
        check("t4b result", 32'(reg_s), 32'd40);
        step();
        check("t4b n_ops", 32'(n_ops), 32'd6);

        // 5: reset during E3
        modo = 2'b00; inicio = 1'b1;
        step();
        inicio = 1'b0;
        step();
        step();
        step();
        check("t5 in E3", 32'(vec), 32'(VE3));
        rst = 1'b0;
        step();
        check("t5 reset vec", 32'(vec), 32'(VIdle));
        check("t5 n_ops", 32'(n_ops), 32'd0);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("t5 quiet c%0d", i), 32'(vec), 32'(VIdle));
        end
        check("t5 n_ops after", 32'(n_ops), 32'd0);
        check("t5 small n_ops", 32'(s_n_ops), 32'd0);

        // 6: five back-to-back clears, 2-bit counter wraps
        for (int r = 0; r < 5; r++) begin
            run_seq($sformatf("t6 r%0d", r), 2'b11);
            check($sformatf("t6 r%0d result", r), 32'(reg_s), 32'd0);
            step();
            check($sformatf("t6 r%0d small n_ops", r), 32'(s_n_ops),
                  (r == 3) ? 32'd0 : 32'(r + 1) % 32'd4);
            check($sformatf("t6 r%0d n_ops", r), 32'(n_ops), 32'(r + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
